upload_rr_scheduler: RTL and testbench
======================================

# upload_rr_scheduler

Round-robin packet scheduler that shares the single processor upload port among `NUM_SOURCES` upload streams. It sits between the upload sources (UART, SPI, I2C, DSO capture, …) and the command processor's upload interface. It grants one source at a time and holds the grant for a whole packet, where a packet is the span during which that source's `req` is high. A stalled source is released by a watchdog so it cannot hang the port.

## Interface
Parameters:
- `NUM_SOURCES`, 4: number of requesters, 2..8.
- `TIMEOUT`, 1024: cycles without a handshake, while granted, before the grant is forcibly released. Must be ≥ 2.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `src_upload_req`  in  NUM_SOURCES  per-source packet-in-progress flag.
- `src_upload_data`  in  NUM_SOURCES*8  per-source data byte; source i occupies bits [i*8 +: 8].
- `src_upload_source`  in  NUM_SOURCES*8  per-source source-ID byte.
- `src_upload_valid`  in  NUM_SOURCES  per-source byte valid.
- `src_upload_ready`  out  NUM_SOURCES  per-source ready.
- `merged_upload_req`  out  1  to processor.
- `merged_upload_data`  out  8  to processor.
- `merged_upload_source`  out  8  to processor.
- `merged_upload_valid`  out  1  to processor.
- `processor_upload_ready`  in  1  from processor.
- `grant`  out  NUM_SOURCES  one-hot registered grant; all zero when idle.
- `timeout_pulse`  out  1  one-cycle pulse when the watchdog releases a grant.

## Operation
- Pending: source i is pending when `src_upload_req[i] | src_upload_valid[i]`.
- State `IDLE`:
  - `grant` = 0.
  - If any source is pending, pick the first pending index after `last_grant`, searching cyclically.
  - Register that index into `grant` and `last_grant`, and go to `LOCK`.
- State `LOCK` (granted index g): pure combinational pass-through.
  - `merged_upload_data`/`merged_upload_source` = source g's bytes.
  - `merged_upload_valid` = `src_upload_valid[g]`.
  - `merged_upload_req` = 1.
  - `src_upload_ready[g]` = `processor_upload_ready`; all other ready bits are 0.
- Release condition, evaluated every cycle in `LOCK`: `!src_upload_req[g] && (!src_upload_valid[g] || processor_upload_ready)`.
  - Covers end of packet, including a final beat that is accepted in the same cycle.
  - Covers single-beat sources that never raise `req`.
  - On release, go to `IDLE` next cycle.
- Packet atomicity: while `src_upload_req[g]` = 1, the grant is never moved, regardless of other sources.
- Watchdog:
  - A counter, width `$clog2(TIMEOUT)+1`, clears on every handshake (`valid & ready`) and on entering `LOCK`; it otherwise increments in `LOCK`.
  - When it reaches `TIMEOUT-1` and no handshake occurs that cycle, force release to `IDLE` and assert `timeout_pulse` for the next cycle.
  - The timed-out source is last in round-robin order afterwards.
- In `IDLE`, every `src_upload_ready` bit is 0 and every merged output is 0. There is no buffering in this block; sources keep their own FIFOs.

## Timing
- Reset values:
  - `grant` = 0; state = `IDLE`.
  - `last_grant` = NUM_SOURCES-1, so source 0 wins first.
  - Watchdog = 0; `timeout_pulse` = 0.
  - All merged outputs and all `src_upload_ready` = 0.
- Grant latency: source pending at edge t makes `grant` valid after edge t+1; the first byte can handshake in that same cycle.
- Release-to-next-grant: exactly one `IDLE` cycle between consecutive grants. A byte is never transferred in `IDLE`.
- Simultaneous requests: resolved cyclically from `last_grant`+1. A source dropping its request while `IDLE` evaluates is simply not chosen.
- A source asserting `req` while another is locked waits. Its bytes are not dropped, because its ready is 0.
- Handshake and release in the same cycle: the byte transfers, then the grant drops next cycle.
- Reset asserted mid-packet: all outputs return to reset values immediately (asynchronously). The in-flight packet is truncated; the source's own FIFO retains unsent bytes.
- `processor_upload_ready` low indefinitely with valid high: the watchdog fires after exactly `TIMEOUT` cycles in `LOCK` without a handshake.

## Test plan
- Single source: source 1 sends a 5-byte packet (req high through the last beat, ready always 1). Required:
  - `grant`=4'b0010 one cycle after the request.
  - Bytes 0x10..0x14 appear in order with source ID 0x02.
  - `grant`=0 on the cycle after byte 0x14.
- Contention from reset: sources 0, 2 and 3 pending together. Required:
  - Grants in order 0, 2, 3.
  - Each grant is separated by exactly one `IDLE` cycle.
- Packet atomicity: source 2 mid-packet (req=1); source 0 then requests. Required:
  - Source 0's ready stays 0 until source 2's req falls and its last byte is accepted.
  - Then source 0 is granted.
- Single-beat source: source 3 sends valid=1, req=0, data 0xA5. Required:
  - One handshake carrying 0xA5.
  - Immediate release: `grant`=0 next cycle.
- Watchdog: `TIMEOUT`=16, source 1 granted with req=1, valid=0 held. Required:
  - `timeout_pulse`=1 for one cycle, 16 cycles after the grant.
  - Then the grant moves to the next pending source.
- Backpressure: `processor_upload_ready` toggles 1,0,1,0 during a 4-byte packet. Required:
  - Data is stable while valid=1 and ready=0.
  - All 4 bytes are delivered with no duplication.
  - No timeout fires.

Source files
------------

// File: rtl/upload_rr_scheduler.sv
// upload_rr_scheduler: round-robin, packet-atomic arbiter of upload streams onto the single processor upload port
//   clk, rst_n                        : clock, asynchronous active-low reset
//   src_upload_req/valid/ready        : per-source packet flag, byte valid, byte ready
//   src_upload_data/source            : per-source data and source-ID bytes, source i at [i*8 +: 8]
//   merged_upload_req/data/source/valid, processor_upload_ready : processor-side stream
//   grant                             : registered one-hot grant, zero when idle
//   timeout_pulse                     : one-cycle strobe when the watchdog releases a stalled grant
module upload_rr_scheduler #(
  parameter int NUM_SOURCES = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_SOURCES-1:0]     src_upload_req,
  input  logic [NUM_SOURCES*8-1:0]   src_upload_data,
  input  logic [NUM_SOURCES*8-1:0]   src_upload_source,
  input  logic [NUM_SOURCES-1:0]     src_upload_valid,
  output logic [NUM_SOURCES-1:0]     src_upload_ready,
  output logic                       merged_upload_req,
  output logic [7:0]                 merged_upload_data,
  output logic [7:0]                 merged_upload_source,
  output logic                       merged_upload_valid,
  input  logic                       processor_upload_ready,
  output logic [NUM_SOURCES-1:0]     grant,
  output logic                       timeout_pulse
);
  localparam int IW = $clog2(NUM_SOURCES);
  localparam int WW = $clog2(TIMEOUT) + 1;
  typedef enum logic {IDLE, LOCK} state_t;
  state_t state;
  logic [IW-1:0] last_grant, pick, cand;
  logic [WW-1:0] wd;
  logic [7:0] data_a [NUM_SOURCES];
  logic [7:0] src_a [NUM_SOURCES];
  logic [NUM_SOURCES-1:0] pending;
  logic lock, hs, rel, expire;
  for (genvar i = 0; i < NUM_SOURCES; i++) begin : g_unpack
    assign data_a[i] = src_upload_data[i*8 +: 8];
    assign src_a[i] = src_upload_source[i*8 +: 8];
  end
  // last_grant doubles as the granted index while locked
  assign pending = src_upload_req | src_upload_valid;
  assign lock = state == LOCK;
  assign hs = lock && src_upload_valid[last_grant] && processor_upload_ready;
  assign rel = lock && !src_upload_req[last_grant] && (!src_upload_valid[last_grant] || processor_upload_ready);
  assign expire = lock && wd == WW'(TIMEOUT - 1) && !hs;
  // scan downward so the nearest pending index after last_grant is written last
  always_comb begin
    pick = last_grant;
    cand = last_grant;
    for (int k = NUM_SOURCES; k > 0; k--) begin
      cand = IW'((int'(last_grant) + k) % NUM_SOURCES);
      if (pending[cand]) pick = cand;
    end
  end
  assign merged_upload_req = lock;
  assign merged_upload_valid = lock && src_upload_valid[last_grant];
  assign merged_upload_data = lock ? data_a[last_grant] : 8'h00;
  assign merged_upload_source = lock ? src_a[last_grant] : 8'h00;
  assign src_upload_ready = grant & {NUM_SOURCES{processor_upload_ready}};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      grant <= '0;
      last_grant <= IW'(NUM_SOURCES - 1);
      wd <= '0;
      timeout_pulse <= 1'b0;
    end else begin
      timeout_pulse <= 1'b0;
      if (!lock) begin
        wd <= '0;
        if (|pending) begin
          state <= LOCK;
          grant <= NUM_SOURCES'(1) << pick;
          last_grant <= pick;
        end
      end else begin
        wd <= hs ? '0 : wd + 1'b1;
        if (rel || expire) begin
          state <= IDLE;
          grant <= '0;
          timeout_pulse <= expire;
        end
      end
    end
  end
endmodule

// File: tb/tb_upload_rr_scheduler.sv
// tb_upload_rr_scheduler: directed self-checking bench for upload_rr_scheduler
module tb_upload_rr_scheduler;
  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] req, valid, ready, grant;
  logic [31:0] data, srcid;
  logic m_req, m_valid, pr, to_pulse;
  logic [7:0] m_data, m_src;
  int n_chk = 0;
  int n_bad = 0;

  upload_rr_scheduler #(.NUM_SOURCES(4), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .src_upload_req(req), .src_upload_data(data), .src_upload_source(srcid),
    .src_upload_valid(valid), .src_upload_ready(ready),
    .merged_upload_req(m_req), .merged_upload_data(m_data),
    .merged_upload_source(m_src), .merged_upload_valid(m_valid),
    .processor_upload_ready(pr), .grant(grant), .timeout_pulse(to_pulse)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL global_timeout: got still running want finished");
    $fatal(1, "bench did not finish");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req = '0; valid = '0; data = 32'hE3E2E1E0; srcid = 32'h5C5B5A59; pr = 1'b0; rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 4'hF; valid = 4'hF; pr = 1'b1; data = 32'h33221100; srcid = 32'h03020100;
    @(posedge clk);
    @(posedge clk);
    #1;
    n_chk++; if (grant !== 4'b0000) begin n_bad++; $display("FAIL reset_grant: got %b want 0000", grant); end
    n_chk++; if (ready !== 4'b0000) begin n_bad++; $display("FAIL reset_ready: got %b want 0000", ready); end
    n_chk++; if ({m_req, m_valid, m_data, m_src} !== 18'd0) begin n_bad++; $display("FAIL reset_merged: got %b %b %h %h want all zero", m_req, m_valid, m_data, m_src); end
    n_chk++; if (to_pulse !== 1'b0) begin n_bad++; $display("FAIL reset_timeout: got %b want 0", to_pulse); end
    rst_n = 1'b1;
    step();
    n_chk++; if (grant !== 4'b0001) begin n_bad++; $display("FAIL reset_first_grant: got %b want 0001", grant); end
  endtask

  task automatic test_single();
    do_reset();
    req[1] = 1'b1; valid[1] = 1'b1; data[15:8] = 8'h10; srcid[15:8] = 8'h02; pr = 1'b1;
    #1;
    n_chk++; if (ready !== 4'b0000 || grant !== 4'b0000) begin n_bad++; $display("FAIL single_idle: got ready=%b grant=%b want 0000 0000", ready, grant); end
    for (int i = 0; i < 5; i++) begin
      step();
      req[1] = (i < 4);
      data[15:8] = 8'h10 + 8'(i);
      #1;
      n_chk++; if (grant !== 4'b0010) begin n_bad++; $display("FAIL single_grant[%0d]: got %b want 0010", i, grant); end
      n_chk++; if (m_data !== 8'h10 + 8'(i) || m_src !== 8'h02) begin n_bad++; $display("FAIL single_byte[%0d]: got %h/%h want %h/02", i, m_data, m_src, 8'h10 + 8'(i)); end
      n_chk++; if (ready !== 4'b0010 || m_valid !== 1'b1) begin n_bad++; $display("FAIL single_hs[%0d]: got ready=%b valid=%b want 0010 1", i, ready, m_valid); end
    end
    step();
    valid[1] = 1'b0;
    #1;
    n_chk++; if (grant !== 4'b0000 || m_req !== 1'b0) begin n_bad++; $display("FAIL single_release: got grant=%b req=%b want 0000 0", grant, m_req); end
  endtask

  task automatic test_contention();
    do_reset();
    req = 4'b1101; pr = 1'b1;
    step();
    n_chk++; if (grant !== 4'b0001) begin n_bad++; $display("FAIL cont_first: got %b want 0001", grant); end
    req[0] = 1'b0;
    step();
    n_chk++; if (grant !== 4'b0000) begin n_bad++; $display("FAIL cont_idle1: got %b want 0000", grant); end
    step();
    n_chk++; if (grant !== 4'b0100) begin n_bad++; $display("FAIL cont_second: got %b want 0100", grant); end
    req[2] = 1'b0;
    step();
    n_chk++; if (grant !== 4'b0000) begin n_bad++; $display("FAIL cont_idle2: got %b want 0000", grant); end
    step();
    n_chk++; if (grant !== 4'b1000) begin n_bad++; $display("FAIL cont_third: got %b want 1000", grant); end
    req[3] = 1'b0;
    step();
    step();
    n_chk++; if (grant !== 4'b0000) begin n_bad++; $display("FAIL cont_quiet: got %b want 0000", grant); end
  endtask

  task automatic test_atomicity();
    do_reset();
    req[2] = 1'b1; valid[2] = 1'b1; data[23:16] = 8'h20; pr = 1'b1;
    step();
    req[0] = 1'b1; valid[0] = 1'b1; data[7:0] = 8'hC0;
    #1;
    n_chk++; if (grant !== 4'b0100 || ready !== 4'b0100 || m_data !== 8'h20) begin n_bad++; $display("FAIL atom_start: got grant=%b ready=%b data=%h want 0100 0100 20", grant, ready, m_data); end
    for (int i = 1; i < 3; i++) begin
      step();
      data[23:16] = 8'h20 + 8'(i);
      #1;
      n_chk++; if (grant !== 4'b0100 || ready !== 4'b0100) begin n_bad++; $display("FAIL atom_hold[%0d]: got grant=%b ready=%b want 0100 0100", i, grant, ready); end
    end
    step();
    req[2] = 1'b0; data[23:16] = 8'h23; pr = 1'b0;
    #1;
    n_chk++; if (ready !== 4'b0000 || m_valid !== 1'b1) begin n_bad++; $display("FAIL atom_stall: got ready=%b valid=%b want 0000 1", ready, m_valid); end
    step();
    pr = 1'b1;
    #1;
    n_chk++; if (grant !== 4'b0100 || ready !== 4'b0100 || m_data !== 8'h23) begin n_bad++; $display("FAIL atom_last: got grant=%b ready=%b data=%h want 0100 0100 23", grant, ready, m_data); end
    step();
    valid[2] = 1'b0;
    #1;
    n_chk++; if (grant !== 4'b0000 || ready !== 4'b0000) begin n_bad++; $display("FAIL atom_idle: got grant=%b ready=%b want 0000 0000", grant, ready); end
    step();
    n_chk++; if (grant !== 4'b0001 || ready !== 4'b0001 || m_data !== 8'hC0) begin n_bad++; $display("FAIL atom_next: got grant=%b ready=%b data=%h want 0001 0001 c0", grant, ready, m_data); end
    req[0] = 1'b0;
    step();
    valid[0] = 1'b0;
    #1;
    n_chk++; if (grant !== 4'b0000) begin n_bad++; $display("FAIL atom_end: got %b want 0000", grant); end
  endtask

  task automatic test_single_beat();
    do_reset();
    valid[3] = 1'b1; data[31:24] = 8'hA5; srcid[31:24] = 8'h03; pr = 1'b1;
    step();
    n_chk++; if (grant !== 4'b1000 || ready !== 4'b1000 || m_valid !== 1'b1) begin n_bad++; $display("FAIL beat_hs: got grant=%b ready=%b valid=%b want 1000 1000 1", grant, ready, m_valid); end
    n_chk++; if (m_data !== 8'hA5 || m_src !== 8'h03) begin n_bad++; $display("FAIL beat_byte: got %h/%h want a5/03", m_data, m_src); end
    step();
    valid[3] = 1'b0;
    #1;
    n_chk++; if (grant !== 4'b0000) begin n_bad++; $display("FAIL beat_release: got %b want 0000", grant); end
    step();
    n_chk++; if (grant !== 4'b0000) begin n_bad++; $display("FAIL beat_no_regrant: got %b want 0000", grant); end
  endtask

  task automatic test_watchdog();
    do_reset();
    req[1] = 1'b1; req[2] = 1'b1; pr = 1'b1;
    step();
    n_chk++; if (grant !== 4'b0010) begin n_bad++; $display("FAIL wd_grant: got %b want 0010", grant); end
    for (int k = 0; k < 15; k++) begin
      step();
      n_chk++; if (grant !== 4'b0010 || to_pulse !== 1'b0) begin n_bad++; $display("FAIL wd_hold[%0d]: got grant=%b pulse=%b want 0010 0", k, grant, to_pulse); end
    end
    step();
    n_chk++; if (grant !== 4'b0000 || to_pulse !== 1'b1) begin n_bad++; $display("FAIL wd_fire: got grant=%b pulse=%b want 0000 1", grant, to_pulse); end
    step();
    n_chk++; if (grant !== 4'b0100 || to_pulse !== 1'b0) begin n_bad++; $display("FAIL wd_next: got grant=%b pulse=%b want 0100 0", grant, to_pulse); end
    req = '0;
    step();
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_b [4];
    logic [7:0] got_b [4];
    int idx, n;
    exp_b[0] = 8'hB0; exp_b[1] = 8'hB1; exp_b[2] = 8'hB2; exp_b[3] = 8'hB3;
    idx = 0; n = 0;
    do_reset();
    req[0] = 1'b1; valid[0] = 1'b1; data[7:0] = exp_b[0]; pr = 1'b1;
    #1;
    n_chk++; if (ready !== 4'b0000) begin n_bad++; $display("FAIL bp_idle: got %b want 0000", ready); end
    step();
    for (int c = 0; c < 7; c++) begin
      pr = (c % 2 == 0);
      data[7:0] = exp_b[idx];
      req[0] = (idx < 3);
      #1;
      n_chk++; if (grant !== 4'b0001 || m_data !== exp_b[idx] || to_pulse !== 1'b0) begin n_bad++; $display("FAIL bp_cycle[%0d]: got grant=%b data=%h pulse=%b want 0001 %h 0", c, grant, m_data, to_pulse, exp_b[idx]); end
      if (ready[0] && m_valid && n < 4) begin
        got_b[n] = m_data;
        n++;
      end
      if (ready[0] && idx < 3) idx++;
      step();
    end
    req[0] = 1'b0; valid[0] = 1'b0;
    #1;
    n_chk++; if (grant !== 4'b0000 || to_pulse !== 1'b0) begin n_bad++; $display("FAIL bp_release: got grant=%b pulse=%b want 0000 0", grant, to_pulse); end
    n_chk++; if (n !== 4) begin n_bad++; $display("FAIL bp_count: got %0d want 4", n); end
    for (int i = 0; i < 4; i++) begin
      n_chk++; if (i >= n || got_b[i] !== exp_b[i]) begin n_bad++; $display("FAIL bp_byte[%0d]: got %h want %h", i, (i < n) ? got_b[i] : 8'hxx, exp_b[i]); end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    req[1] = 1'b1; valid[1] = 1'b1; pr = 1'b1;
    step();
    n_chk++; if (grant !== 4'b0010 || m_req !== 1'b1) begin n_bad++; $display("FAIL areset_pre: got grant=%b req=%b want 0010 1", grant, m_req); end
    #2;
    rst_n = 1'b0;
    #1;
    n_chk++; if (grant !== 4'b0000 || ready !== 4'b0000 || m_req !== 1'b0 || m_valid !== 1'b0) begin n_bad++; $display("FAIL areset_now: got grant=%b ready=%b req=%b valid=%b want 0000 0000 0 0", grant, ready, m_req, m_valid); end
    req = '0; valid = '0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_atomicity();
    test_single_beat();
    test_watchdog();
    test_backpressure();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
